fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 RESET_PC, 32'h0000_0000, address of first fetch after reset; bits [1:0] SHALL be zero.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 imem_req_valid  out  1  instruction memory request valid.
REQ-005 imem_req_ready  in  1  memory accepts request this cycle.
REQ-006 imem_req_addr  out  32  word-aligned fetch address.
REQ-007 imem_rsp_valid  in  1  read data valid; at most one response per accepted request, in order.
REQ-008 imem_rsp_data  in  32  instruction word.
REQ-009 redirect_valid  in  1  pipeline flush / control transfer from writeback.
REQ-010 redirect_pc  in  32  new fetch target; bits [1:0] SHALL be ignored and treated as 0.
REQ-011 instr_addr_out  out  32  address of instruction presented to decode.
REQ-012 instr_dat_out  out  32  instruction word presented to decode.
REQ-013 stall_out_ft  out  1  1 = no valid instruction this cycle (bubble to decode).
REQ-014 stall_in_ft  in  1  1 = decode cannot accept; hold outputs.

Function
REQ-015 Block SHALL contain pc (32 b), a 2-entry FIFO of {addr, data}, an in-flight address register, and FSM states REQ, WAIT, DROP.
REQ-016 At most one memory request SHALL be outstanding.
REQ-017 REQ: imem_req_valid=1 and imem_req_addr=pc only if FIFO occupancy < 2; else imem_req_valid=0.
REQ-018 REQ with imem_req_valid & imem_req_ready: in-flight addr <= pc, pc <= pc+4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000), next state WAIT.
REQ-019 WAIT with imem_rsp_valid: push {in-flight addr, imem_rsp_data} to FIFO, next state REQ; response in same cycle as acceptance SHALL NOT occur (min latency 1).
REQ-020 FIFO head SHALL drive instr_addr_out/instr_dat_out combinationally; stall_out_ft = FIFO empty.
REQ-021 Head SHALL pop when FIFO non-empty and stall_in_ft=0; while stall_in_ft=1 outputs SHALL hold stable.
REQ-022 Simultaneous push and pop SHALL be permitted at any occupancy including 2 (occupancy unchanged); push when full without pop cannot occur by REQ-017.
REQ-023 redirect_valid SHALL have priority over all other events in that cycle: FIFO cleared, any pop/push discarded, pc <= {redirect_pc[31:2],2'b00}.
REQ-024 On redirect: from REQ without handshake -> REQ; from REQ with handshake same cycle -> DROP; from WAIT without rsp -> DROP; from WAIT with rsp same cycle -> REQ (response discarded); from DROP without rsp -> DROP; from DROP with rsp same cycle -> REQ.
REQ-025 DROP: imem_req_valid=0; on imem_rsp_valid discard data, next state REQ.
REQ-026 stall_out_ft SHALL be 1 in the cycle after a redirect, the first possible valid instruction being the redirect target.
REQ-027 Fetch order SHALL be strictly sequential between redirects; no branch prediction.

Reset
REQ-028 While rst=1: pc=RESET_PC, FIFO empty, state REQ, imem_req_valid=0, stall_out_ft=1, instr_addr_out=0, instr_dat_out=0.
REQ-029 Reset asserted mid-request SHALL abandon the transaction; a response arriving after reset release while in REQ SHALL be ignored.
REQ-030 First request SHALL issue in the first cycle after rst deasserts, at RESET_PC.

Verification
REQ-031 Reset release, memory ready always, 1-cycle latency, stall_in_ft=0 -> requests 0x0,0x4,0x8 in order; decode sees same addrs with matching data, each once.
REQ-032 stall_in_ft=1 for 6 cycles -> FIFO fills to 2, imem_req_valid drops to 0, outputs stable; release -> 2 pops then fetch resumes with no gap or duplicate.
REQ-033 Redirect to 0x100 while in WAIT, response 3 cycles later -> that response discarded, next request 0x100, stall_out_ft=1 until 0x100 delivered.
REQ-034 Redirect coincident with imem_rsp_valid and pop -> FIFO empty next cycle, next request at target, no stale instruction reaches decode.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 redirect_pc=0x203 -> fetch address 0x200; rst pulsed mid-WAIT -> outputs reset values immediately, next request RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues sequential word-aligned fetches to instruction memory. At most one
// request is outstanding. Responses go into a 2-entry {addr, data} FIFO whose
// head is presented to decode. A redirect flushes the FIFO, retargets the pc
// and discards any response still owed by memory.
//
// State table:
//   ST_REQ  | may issue a request at pc when the FIFO has room
//   ST_WAIT | request accepted, waiting for its response
//   ST_DROP | request outstanding whose response must be discarded
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   imem_req_valid/ready/addr       fetch request handshake
//   imem_rsp_valid/data             fetch response (min latency 1, in order)
//   redirect_valid/redirect_pc      flush and new fetch target
//   instr_addr_out/instr_dat_out    FIFO head to decode (0 when empty)
//   stall_out_ft                    1 = no valid instruction (FIFO empty)
//   stall_in_ft                     1 = decode holding, no pop
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr_addr_out,
   output logic [31:0] instr_dat_out,
   output logic        stall_out_ft,
   input  logic        stall_in_ft
);

   typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] infl_q, infl_d;
   logic [31:0] fifo_addr_q [2];
   logic [31:0] fifo_addr_d [2];
   logic [31:0] fifo_data_q [2];
   logic [31:0] fifo_data_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;

   logic        req_fire;
   logic        push;
   logic        pop;

   // Gated by rst so the request line is low for the whole reset window,
   // while still allowing the first request in the first cycle after release.
   assign imem_req_valid = ~rst & (state_q == ST_REQ) & (count_q != 2'd2);
   assign imem_req_addr  = pc_q;

   assign stall_out_ft   = (count_q == 2'd0);
   assign instr_addr_out = stall_out_ft ? 32'd0 : fifo_addr_q[rd_ptr_q];
   assign instr_dat_out  = stall_out_ft ? 32'd0 : fifo_data_q[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      infl_d      = infl_q;
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;

      req_fire = imem_req_valid & imem_req_ready;
      push     = (state_q == ST_WAIT) & imem_rsp_valid;
      pop      = (count_q != 2'd0) & ~stall_in_ft;

      if (req_fire) begin
         infl_d = pc_q;
         pc_d   = pc_q + 32'd4;
      end

      case (state_q)
         ST_REQ:  if (req_fire)      state_d = ST_WAIT;
         ST_WAIT: if (imem_rsp_valid) state_d = ST_REQ;
         ST_DROP: if (imem_rsp_valid) state_d = ST_REQ;
         default:                    state_d = ST_REQ;
      endcase

      if (redirect_valid) begin
         // Redirect overrides every other event this cycle.
         pc_d     = redirect_pc & 32'hFFFF_FFFC;
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         case (state_q)
            ST_REQ:  state_d = req_fire ? ST_DROP : ST_REQ;
            ST_WAIT,
            ST_DROP: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
            default: state_d = ST_REQ;
         endcase
      end else begin
         if (push) begin
            fifo_addr_d[wr_ptr_q] = infl_q;
            fifo_data_d[wr_ptr_q] = imem_rsp_data;
            wr_ptr_d              = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_REQ;
         pc_q     <= RESET_PC & 32'hFFFF_FFFC;
         infl_q   <= 32'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_addr_q[i] <= 32'd0;
            fifo_data_q[i] <= 32'd0;
         end
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         infl_q   <= infl_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < 2; i++) begin
            fifo_addr_q[i] <= fifo_addr_d[i];
            fifo_data_q[i] <= fifo_data_d[i];
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit with a memory model and a
// scoreboard of the addresses decode should see (sequential from the last
// reset/redirect target). Memory data is a fixed hash of the address.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] instr_addr_out;
   logic [31:0] instr_dat_out;
   logic        stall_out_ft;
   logic        stall_in_ft;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_addr_out (instr_addr_out),
      .instr_dat_out  (instr_dat_out),
      .stall_out_ft   (stall_out_ft),
      .stall_in_ft    (stall_in_ft)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int ndeliv = 0;

   logic [31:0] expq [$];

   // memory model state
   bit          pend = 0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = 0;
   logic [31:0] req_exp = RST_PC;

   // stimulus knobs
   int lat_lo = 1, lat_hi = 1;
   int p_ready = 100;
   int stall_mode = 0;   // 0 never, 1 always, 2 random
   int p_stall = 30;
   bit auto_redir = 0;
   bit auto_hit = 0;
   logic [31:0] auto_tgt = 0;

   function automatic logic [31:0] hash(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic refill(input logic [31:0] start);
      expq.delete();
      for (int i = 0; i < 1024; i++) expq.push_back(start + 32'(i * 4));
   endtask

   task automatic step(input bit rst_v, input bit redir_in, input logic [31:0] tgt_in);
      bit          redir;
      logic [31:0] tgt;
      redir = redir_in;
      tgt   = tgt_in;
      @(negedge clk);
      rst = rst_v;
      if (pend) pend_cnt--;
      if (pend && pend_cnt == 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = hash(pend_addr);
         pend           = 0;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      imem_req_ready = ($urandom_range(99) < p_ready);
      case (stall_mode)
         1:       stall_in_ft = 1'b1;
         2:       stall_in_ft = ($urandom_range(99) < p_stall);
         default: stall_in_ft = 1'b0;
      endcase
      if (auto_redir && imem_rsp_valid && !stall_out_ft && !stall_in_ft && !rst_v) begin
         redir      = 1;
         tgt        = auto_tgt;
         auto_hit   = 1;
         auto_redir = 0;
      end
      redirect_valid = redir;
      redirect_pc    = redir ? tgt : $urandom;
      if (rst_v) begin
         req_exp = RST_PC;
         refill(RST_PC);
      end
      if (redir) refill(tgt & 32'hFFFF_FFFC);
      #1;
      if (!rst_v && imem_req_valid && imem_req_ready) begin
         chk("one_outstanding", 32'(pend), 32'd0);
         chk("req_addr", imem_req_addr, req_exp);
         req_exp   = req_exp + 32'd4;
         pend      = 1;
         pend_cnt  = $urandom_range(lat_hi, lat_lo);
         pend_addr = imem_req_addr;
      end
      if (redir) req_exp = tgt & 32'hFFFF_FFFC;
   endtask

   // Monitor: checks decode-side outputs against the scoreboard.
   initial begin
      bit          prev_hold;
      bit          prev_redir;
      logic [31:0] pa, pd, e;
      prev_hold  = 0;
      prev_redir = 0;
      pa = 0;
      pd = 0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_stall_out", 32'(stall_out_ft), 32'd1);
            chk("rst_addr_out", instr_addr_out, 32'd0);
            chk("rst_dat_out", instr_dat_out, 32'd0);
            prev_hold  = 0;
            prev_redir = 0;
         end else begin
            if (prev_redir) chk("stall_after_redirect", 32'(stall_out_ft), 32'd1);
            if (prev_hold) begin
               chk("hold_valid", 32'(stall_out_ft), 32'd0);
               chk("hold_addr", instr_addr_out, pa);
               chk("hold_dat", instr_dat_out, pd);
            end
            if (!stall_out_ft && !stall_in_ft && !redirect_valid) begin
               if (expq.size() == 0) begin
                  chk("scoreboard_underflow", 32'(expq.size()), 32'd1);
               end else begin
                  e = expq.pop_front();
                  chk("dec_addr", instr_addr_out, e);
                  chk("dec_dat", instr_dat_out, hash(e));
                  ndeliv++;
               end
            end
            prev_hold  = !stall_out_ft && stall_in_ft && !redirect_valid;
            prev_redir = redirect_valid;
            pa         = instr_addr_out;
            pd         = instr_dat_out;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      bit got;
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      stall_in_ft    = 1'b0;
      refill(RST_PC);

      // reset release, always ready, latency 1, no stall; wraps through 0
      repeat (3) step(1, 0, 0);
      step(0, 0, 0);
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_req_addr, RST_PC);
      n0 = ndeliv;
      repeat (20) step(0, 0, 0);
      chk("phase1_progress", 32'((ndeliv - n0) >= 8), 32'd1);

      // decode stalls 6 cycles: FIFO fills and request line drops
      stall_mode = 1;
      repeat (6) step(0, 0, 0);
      chk("full_req_valid", 32'(imem_req_valid), 32'd0);
      chk("full_has_instr", 32'(stall_out_ft), 32'd0);
      stall_mode = 0;
      n0 = ndeliv;
      repeat (12) step(0, 0, 0);
      chk("resume_progress", 32'((ndeliv - n0) >= 4), 32'd1);

      // redirect while WAIT, response 3 cycles after acceptance
      lat_lo = 3; lat_hi = 3;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         step(0, 0, 0);
         got = pend;
      end
      chk("wait_reached", 32'(got), 32'd1);
      step(0, 1, 32'h0000_0100);
      lat_lo = 1; lat_hi = 1;
      n0 = ndeliv;
      repeat (15) step(0, 0, 0);
      chk("redir100_progress", 32'(ndeliv > n0), 32'd1);

      // redirect coincident with response and pop
      lat_lo = 1; lat_hi = 2;
      stall_mode = 2; p_stall = 50;
      auto_tgt = 32'h0000_0400; auto_hit = 0; auto_redir = 1;
      for (int i = 0; i < 200 && !auto_hit; i++) step(0, 0, 0);
      auto_redir = 0;
      chk("coincident_redirect_hit", 32'(auto_hit), 32'd1);
      stall_mode = 0;
      repeat (10) step(0, 0, 0);

      // unaligned redirect target
      step(0, 1, 32'h0000_0203);
      n0 = ndeliv;
      repeat (12) step(0, 0, 0);
      chk("redir203_progress", 32'(ndeliv > n0), 32'd1);

      // randomized traffic
      lat_lo = 1; lat_hi = 3; p_ready = 70; stall_mode = 2; p_stall = 30;
      n0 = ndeliv;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 4) begin
            if ($urandom_range(3) == 0) step(0, 1, 32'hFFFF_FFF0 | 32'($urandom_range(15)));
            else                        step(0, 1, $urandom);
         end else begin
            step(0, 0, 0);
         end
      end
      chk("random_progress", 32'((ndeliv - n0) >= 200), 32'd1);

      // reset pulsed mid-WAIT; stale response lands in first cycle after release
      lat_lo = 3; lat_hi = 3; p_ready = 100; stall_mode = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         step(0, 0, 0);
         got = pend;
      end
      chk("wait_before_reset", 32'(got), 32'd1);
      step(1, 0, 0);
      chk("rst_imm_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_imm_stall", 32'(stall_out_ft), 32'd1);
      chk("rst_imm_addr", instr_addr_out, 32'd0);
      for (int i = 0; i < 10 && pend && pend_cnt != 1; i++) step(1, 0, 0);
      lat_lo = 1; lat_hi = 1;
      step(0, 0, 0);
      chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
      chk("post_rst_req_addr", imem_req_addr, RST_PC);
      n0 = ndeliv;
      repeat (20) step(0, 0, 0);
      chk("post_rst_progress", 32'((ndeliv - n0) >= 8), 32'd1);

      @(negedge clk);
      #3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
